branch_pred_unit: RTL and testbench
===================================

# branch_pred_unit

Parametrised branch prediction unit for the 4-stage RISC-V core: tagged BTB, gshare/bimodal direction counters, and a return-address stack. It is looked up with the IF-stage PC and updated from the EM stage. It replaces the untagged BTB plus fixed bimodal predictor pair with one block that has speculative history, misprediction recovery and a self-clearing power-up sequence.

## Interface
Parameters:
- INDEX_WIDTH, 10: log2 of BTB and counter-table entries.
- HIST_WIDTH, 8: global history bits. 0 selects bimodal mode. Must be ≤ INDEX_WIDTH.
- TAG_WIDTH, 8: BTB tag bits, taken as pc[INDEX_WIDTH+2 +: TAG_WIDTH].
- RAS_DEPTH, 4: return stack entries. Power of two, ≥2. RP = log2(RAS_DEPTH).
- META_W: RP+HIST_WIDTH+2, derived, not overridable.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- busy  out  1  table clear in progress.
- pred_oe  in  1  lookup enable (processor drives !stall[ID]).
- pred_pc  in  32  fetch PC.
- pred_taken  out  1  predicted taken.
- pred_target  out  32  predicted next PC.
- pred_meta  out  META_W  {ras_ptr, ghr, ctr} snapshot; pipelined by the processor.
- fb_we  in  1  resolved control transfer in EM.
- fb_pc  in  32  PC of resolved instruction.
- fb_taken  in  1  actual direction.
- fb_target  in  32  actual target.
- fb_kind  in  2  0 BRANCH, 1 JUMP, 2 CALL, 3 RET.
- fb_meta  in  META_W  pred_meta returned from EM.
- fb_mispredict  in  1  direction or target wrong.
- cnt_pred  out  32  resolved feedbacks counted.
- cnt_hit  out  32  correct predictions counted.

## Operation
- States: INIT and RUN.
  - rst_n low forces INIT and clears the sweep index, ghr, ras_ptr, all registered outputs and both counters.
  - INIT writes counter=2'b01 and BTB valid=0 to one index per cycle, 0 up to 2^INDEX_WIDTH-1, then enters RUN.
- busy=1 in INIT. pred_oe and fb_we are ignored in INIT.
- Counter index:
  - Lookup: pc[2 +: INDEX_WIDTH] XOR zero-extended ghr.
  - Feedback: fb_pc[2 +: INDEX_WIDTH] XOR fb_meta ghr field.
  - HIST_WIDTH=0: PC bits only.
- BTB index is PC bits only. hit = valid && tag match.
- Prediction (RUN, pred_oe=1):
  - Miss: taken=0, target=pc+4.
  - Hit BRANCH: taken=ctr[1]; target = btb_target if taken, else pc+4.
  - Hit JUMP or CALL: taken=1, target=btb_target.
  - Hit RET: taken=1, target=ras[ras_ptr-1].
- Speculative state on lookup:
  - Hit BRANCH shifts the predicted direction into ghr LSB.
  - Hit CALL: ras[ras_ptr] <= pc+4, ras_ptr+1.
  - Hit RET: ras_ptr-1.
  - RAS wraps modulo RAS_DEPTH. Overflow overwrites the oldest entry; underflow pops stale data. Neither is flagged.
- Feedback (RUN, fb_we=1):
  - BRANCH counter saturates: +1 if fb_taken (max 3), -1 otherwise (min 0). Other kinds leave counters unchanged.
  - BTB written {valid=1, tag, fb_target, fb_kind} only when fb_taken=1.
  - fb_mispredict=1 restores state from fb_meta:
    - ghr <= {fb_meta.ghr[HIST_WIDTH-2:0], fb_taken} for BRANCH; fb_meta.ghr for other kinds.
    - ras_ptr <= fb_meta.ras_ptr, then +1 for CALL or -1 for RET.
  - cnt_pred +1 per fb_we. cnt_hit +1 when fb_mispredict=0. Both wrap at 2^32.
- pred_meta carries ghr and ras_ptr as they were before the lookup's own speculative update, plus the raw counter.

## Timing
- Lookup latency 1: pred_pc sampled at the edge with pred_oe=1; pred_* valid after that edge.
- pred_* hold their value while pred_oe=0.
- Feedback commits at the edge where fb_we=1. A lookup at the same edge to the same index reads the pre-update entry.
- Mispredict restore and lookup at the same edge: the restore wins. The lookup's outputs are produced with the pre-restore ghr and its speculative update is dropped.
- INIT lasts exactly 2^INDEX_WIDTH cycles after rst_n rises. busy falls on the edge that completes the last index.
- rst_n asserted mid-INIT or mid-RUN restarts INIT. Outputs clear immediately, without waiting for a clock.
- Reset values: busy=1; pred_taken=0, pred_target=0, pred_meta=0, cnt_pred=0, cnt_hit=0.

## Test plan
- Reset then wait (INDEX_WIDTH=4) → busy=1 for 16 cycles, then 0. The first lookup of 0x100 gives taken=0, target=0x104.
- Feedback BRANCH pc=0x200, taken, target=0x180, ×2 → next lookup of 0x200 gives taken=1, target=0x180. Two not-taken feedbacks → taken=0, target=0x204.
- Feedback CALL at 0x300→0x400 and RET at 0x410. Then lookup 0x300, then 0x410 → the second lookup gives taken=1, target=0x304.
- RAS_DEPTH=4, five nested calls then five returns → the first four returns target in reverse order. The fifth return target equals the most recent call's return address, because the stack wrapped.
- A speculative BRANCH-taken lookup followed by feedback with fb_mispredict=1, fb_taken=0, fb_meta ghr=0x5A → the ghr used on the next lookup is 0xB4.
- Assert rst_n=0 during RUN with cnt_pred=7 → all outputs are 0 and busy=1 immediately, without a clock edge.

Source files
------------

// File: rtl/branch_pred_unit.sv
// branch_pred_unit: tagged BTB, gshare/bimodal counters, return stack.
// Looked up with the IF PC, trained and repaired from EM.
module branch_pred_unit #(
  parameter int INDEX_WIDTH = 10,
  parameter int HIST_WIDTH  = 8,
  parameter int TAG_WIDTH   = 8,
  parameter int RAS_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        busy,
  input  logic        pred_oe,
  input  logic [31:0] pred_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic [$clog2(RAS_DEPTH)+HIST_WIDTH+1:0] pred_meta,
  input  logic        fb_we,
  input  logic [31:0] fb_pc,
  input  logic        fb_taken,
  input  logic [31:0] fb_target,
  input  logic [1:0]  fb_kind,
  input  logic [$clog2(RAS_DEPTH)+HIST_WIDTH+1:0] fb_meta,
  input  logic        fb_mispredict,
  output logic [31:0] cnt_pred,
  output logic [31:0] cnt_hit
);
  localparam int IW = INDEX_WIDTH;
  localparam int RP = $clog2(RAS_DEPTH);
  localparam int MW = RP + HIST_WIDTH + 2;
  localparam int GW = (HIST_WIDTH > 0) ? HIST_WIDTH : 1;
  localparam int N  = 1 << IW;
  localparam logic [GW-1:0] GMASK = (HIST_WIDTH > 0) ? {GW{1'b1}} : '0;

  localparam logic [1:0] K_BR   = 2'd0;
  localparam logic [1:0] K_JMP  = 2'd1;
  localparam logic [1:0] K_CALL = 2'd2;
  localparam logic [1:0] K_RET  = 2'd3;

  typedef enum logic {INIT, RUN} state_e;

  logic [1:0]           ctr_q    [N];
  logic                 btb_v    [N];
  logic [TAG_WIDTH-1:0] btb_tag  [N];
  logic [31:0]          btb_tgt  [N];
  logic [1:0]           btb_kind [N];
  logic [31:0]          ras      [RAS_DEPTH];

  state_e        state;
  logic [IW-1:0] sweep;
  logic [GW-1:0] ghr;
  logic [RP-1:0] ras_ptr;

  logic [IW-1:0] lk_bi, lk_ci, fb_bi, fb_ci;
  logic          lk_hit;
  logic [1:0]    lk_ctr, lk_kind;
  logic [31:0]   lk_seq;
  logic [MW-1:0] lk_meta;
  logic [GW-1:0] fb_ghr;
  logic [RP-1:0] fb_ptr;
  logic [1:0]    fb_ctr, fb_ctr_nx;
  logic          unused_ok;

  assign busy      = (state == INIT);
  assign unused_ok = ^{pred_pc, fb_pc, fb_meta};

  assign lk_bi   = pred_pc[2 +: IW];
  assign lk_ci   = lk_bi ^ IW'(ghr);
  assign lk_ctr  = ctr_q[lk_ci];
  assign lk_kind = btb_kind[lk_bi];
  assign lk_seq  = pred_pc + 32'd4;
  assign lk_hit  = btb_v[lk_bi] &&
                   (btb_tag[lk_bi] == pred_pc[IW+2 +: TAG_WIDTH]);

  assign fb_ptr = fb_meta[HIST_WIDTH+2 +: RP];
  assign fb_bi  = fb_pc[2 +: IW];
  assign fb_ci  = fb_bi ^ IW'(fb_ghr);
  assign fb_ctr = ctr_q[fb_ci];

  generate
    if (HIST_WIDTH > 0) begin : g_hist
      assign fb_ghr  = fb_meta[2 +: GW];
      assign lk_meta = {ras_ptr, ghr, lk_ctr};
    end else begin : g_bimodal
      assign fb_ghr  = '0;
      assign lk_meta = {ras_ptr, lk_ctr};
    end
  endgenerate

  always_comb begin
    fb_ctr_nx = fb_ctr;
    if (fb_taken && fb_ctr != 2'b11)
      fb_ctr_nx = fb_ctr + 2'd1;
    else if (!fb_taken && fb_ctr != 2'b00)
      fb_ctr_nx = fb_ctr - 2'd1;
  end

  logic          lk_taken, ras_push;
  logic [31:0]   lk_tgt;
  logic [GW-1:0] sp_ghr;
  logic [RP-1:0] sp_ptr;

  always_comb begin
    lk_taken = 1'b0;
    lk_tgt   = lk_seq;
    sp_ghr   = ghr;
    sp_ptr   = ras_ptr;
    ras_push = 1'b0;
    if (lk_hit) begin
      unique case (1'b1)
        lk_kind == K_BR: begin
          lk_taken = lk_ctr[1];
          if (lk_ctr[1]) lk_tgt = btb_tgt[lk_bi];
          sp_ghr = GW'({ghr, lk_ctr[1]}) & GMASK;
        end
        lk_kind == K_JMP: begin
          lk_taken = 1'b1;
          lk_tgt   = btb_tgt[lk_bi];
        end
        lk_kind == K_CALL: begin
          lk_taken = 1'b1;
          lk_tgt   = btb_tgt[lk_bi];
          sp_ptr   = ras_ptr + RP'(1);
          ras_push = 1'b1;
        end
        lk_kind == K_RET: begin
          lk_taken = 1'b1;
          lk_tgt   = ras[ras_ptr - RP'(1)];
          sp_ptr   = ras_ptr - RP'(1);
        end
      endcase
    end
  end

  logic [GW-1:0] rs_ghr;
  logic [RP-1:0] rs_ptr;

  always_comb begin
    rs_ghr = fb_ghr;
    rs_ptr = fb_ptr;
    unique case (1'b1)
      fb_kind == K_BR:   rs_ghr = GW'({fb_ghr, fb_taken}) & GMASK;
      fb_kind == K_CALL: rs_ptr = fb_ptr + RP'(1);
      fb_kind == K_RET:  rs_ptr = fb_ptr - RP'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT;
      sweep       <= '0;
      ghr         <= '0;
      ras_ptr     <= '0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
      pred_meta   <= '0;
      cnt_pred    <= '0;
      cnt_hit     <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
    end else begin
      unique case (state)
        INIT: begin
          sweep <= sweep + IW'(1);
          if (&sweep) state <= RUN;
        end
        RUN: begin
          if (pred_oe) begin
            pred_taken  <= lk_taken;
            pred_target <= lk_tgt;
            pred_meta   <= lk_meta;
          end
          // a repair from EM overrides this cycle's speculation
          if (fb_we && fb_mispredict) begin
            ghr     <= rs_ghr;
            ras_ptr <= rs_ptr;
          end else if (pred_oe) begin
            ghr     <= sp_ghr;
            ras_ptr <= sp_ptr;
            if (ras_push) ras[ras_ptr] <= lk_seq;
          end
          if (fb_we) begin
            cnt_pred <= cnt_pred + 32'd1;
            if (!fb_mispredict) cnt_hit <= cnt_hit + 32'd1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      ctr_q[sweep] <= 2'b01;
      btb_v[sweep] <= 1'b0;
    end else if (fb_we) begin
      if (fb_kind == K_BR) ctr_q[fb_ci] <= fb_ctr_nx;
      if (fb_taken) begin
        btb_v[fb_bi]    <= 1'b1;
        btb_tag[fb_bi]  <= fb_pc[IW+2 +: TAG_WIDTH];
        btb_tgt[fb_bi]  <= fb_target;
        btb_kind[fb_bi] <= fb_kind;
      end
    end
  end

endmodule

// File: tb/tb_branch_pred_unit.sv
// tb_branch_pred_unit: directed scenarios plus randomized traffic
// checked against a behavioural predictor model.
module tb_branch_pred_unit;
  localparam int IW = 8, HW = 8, TW = 8, RD = 4, MW = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic busy, pred_oe, pred_taken, fb_we, fb_taken, fb_mispredict;
  logic [31:0] pred_pc, pred_target, fb_pc, fb_target, cnt_pred, cnt_hit;
  logic [1:0] fb_kind;
  logic [MW-1:0] pred_meta, fb_meta;

  always #5 clk = ~clk;

  branch_pred_unit #(
    .INDEX_WIDTH(IW), .HIST_WIDTH(HW), .TAG_WIDTH(TW), .RAS_DEPTH(RD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .busy(busy),
    .pred_oe(pred_oe), .pred_pc(pred_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_meta(pred_meta),
    .fb_we(fb_we), .fb_pc(fb_pc), .fb_taken(fb_taken),
    .fb_target(fb_target), .fb_kind(fb_kind), .fb_meta(fb_meta),
    .fb_mispredict(fb_mispredict),
    .cnt_pred(cnt_pred), .cnt_hit(cnt_hit)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model state
  int          m_ctr [256];
  bit          m_v   [256];
  int          m_tag [256];
  logic [31:0] m_tgt [256];
  int          m_kind[256];
  logic [31:0] m_ras [4];
  int          m_ghr, m_ptr;
  logic        e_taken;
  logic [31:0] e_target, e_cp, e_ch;
  logic [11:0] e_meta;

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) begin
      m_ctr[i] = 1; m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_kind[i] = 0;
    end
    for (int i = 0; i < 4; i++) m_ras[i] = 0;
    m_ghr = 0; m_ptr = 0;
    e_taken = 0; e_target = 0; e_meta = 0; e_cp = 0; e_ch = 0;
  endfunction

  function automatic void model_step(
    input bit lk, input logic [31:0] pc, input bit fw,
    input logic [31:0] fpc, input bit ft, input logic [31:0] ftgt,
    input logic [1:0] fk, input logic [11:0] fm, input bit fmis);
    int bi, ci, c, s_ghr, s_ptr, fg, fp, fbi, fci;
    bit push, t;
    s_ghr = m_ghr; s_ptr = m_ptr; push = 0;
    if (lk) begin
      bi = int'((pc >> 2) & 32'hFF);
      ci = bi ^ m_ghr;
      c  = m_ctr[ci];
      e_meta = 12'((m_ptr << 10) | (m_ghr << 2) | c);
      e_taken = 0; e_target = pc + 4;
      if (m_v[bi] && m_tag[bi] == int'((pc >> 10) & 32'hFF)) begin
        case (m_kind[bi])
          0: begin
            t = (c >= 2);
            e_taken = t;
            if (t) e_target = m_tgt[bi];
            s_ghr = ((m_ghr << 1) | int'(t)) & 255;
          end
          1: begin e_taken = 1; e_target = m_tgt[bi]; end
          2: begin
            e_taken = 1; e_target = m_tgt[bi];
            push = 1; s_ptr = (m_ptr + 1) % 4;
          end
          default: begin
            e_taken = 1; e_target = m_ras[(m_ptr + 3) % 4];
            s_ptr = (m_ptr + 3) % 4;
          end
        endcase
      end
    end
    if (fw) begin
      fg = int'((fm >> 2) & 12'hFF);
      fp = int'((fm >> 10) & 12'h3);
      fbi = int'((fpc >> 2) & 32'hFF);
      fci = fbi ^ fg;
      if (fk == 0) begin
        if (ft) m_ctr[fci] = (m_ctr[fci] == 3) ? 3 : m_ctr[fci] + 1;
        else    m_ctr[fci] = (m_ctr[fci] == 0) ? 0 : m_ctr[fci] - 1;
      end
      if (ft) begin
        m_v[fbi] = 1; m_tag[fbi] = int'((fpc >> 10) & 32'hFF);
        m_tgt[fbi] = ftgt; m_kind[fbi] = int'(fk);
      end
      e_cp = e_cp + 1;
      if (!fmis) e_ch = e_ch + 1;
    end
    if (fw && fmis) begin
      m_ghr = (fk == 0) ? (((fg << 1) | int'(ft)) & 255) : fg;
      m_ptr = (fp + ((fk == 2) ? 1 : (fk == 3) ? 3 : 0)) % 4;
    end else begin
      if (push) m_ras[m_ptr] = pc + 4;
      m_ghr = s_ghr; m_ptr = s_ptr;
    end
  endfunction

  task automatic step(
    input bit lk, input logic [31:0] pc, input bit fw,
    input logic [31:0] fpc, input bit ft, input logic [31:0] ftgt,
    input logic [1:0] fk, input logic [11:0] fm, input bit fmis);
    @(negedge clk);
    pred_oe = lk; pred_pc = pc;
    fb_we = fw; fb_pc = fpc; fb_taken = ft; fb_target = ftgt;
    fb_kind = fk; fb_meta = fm; fb_mispredict = fmis;
    @(posedge clk);
    model_step(lk, pc, fw, fpc, ft, ftgt, fk, fm, fmis);
    #1;
    pred_oe = 0; fb_we = 0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    step(1, pc, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic feedback(
    input logic [31:0] fpc, input bit ft, input logic [31:0] ftgt,
    input logic [1:0] fk, input logic [11:0] fm, input bit fmis);
    step(0, 0, 1, fpc, ft, ftgt, fk, fm, fmis);
  endtask

  task automatic test_reset();
    int n;
    #2 rst_n = 0;
    #10;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL reset_busy: got %b want 1", busy);
    end
    n_cmp++;
    if ({pred_taken, pred_target, pred_meta, cnt_pred, cnt_hit} !== '0) begin
      n_bad++;
      $display("FAIL reset_outs: got %b %h %h %h %h want all 0",
               pred_taken, pred_target, pred_meta, cnt_pred, cnt_hit);
    end
    // lookups and feedback offered during the sweep must be dropped
    pred_oe = 1; pred_pc = 32'h100;
    fb_we = 1; fb_pc = 32'h100; fb_taken = 1; fb_target = 32'h999;
    fb_kind = 1; fb_meta = 0; fb_mispredict = 0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
    n = 0;
    while (busy && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    pred_oe = 0; fb_we = 0;
    n_cmp++;
    if (n !== 256) begin
      n_bad++; $display("FAIL init_cycles: got %0d want 256", n);
    end
    n_cmp++;
    if (pred_target !== 32'h0 || cnt_pred !== 32'h0) begin
      n_bad++;
      $display("FAIL init_ignores_io: got tgt %h cnt %h want 0 0",
               pred_target, cnt_pred);
    end
  endtask

  task automatic test_first_lookup();
    lookup(32'h100);
    n_cmp++;
    if ({pred_taken, pred_target, pred_meta} !== {1'b0, 32'h104, 12'h001}) begin
      n_bad++;
      $display("FAIL first_lookup: got %b %h %h want 0 00000104 001",
               pred_taken, pred_target, pred_meta);
    end
  endtask

  task automatic test_branch_train();
    feedback(32'h200, 1, 32'h180, 0, 12'h000, 0);
    feedback(32'h200, 1, 32'h180, 0, 12'h000, 0);
    n_cmp++;
    if (cnt_pred !== 32'd2 || cnt_hit !== 32'd2 || pred_target !== 32'h104) begin
      n_bad++;
      $display("FAIL train_cnt_hold: got %0d %0d %h want 2 2 00000104",
               cnt_pred, cnt_hit, pred_target);
    end
    lookup(32'h200);
    n_cmp++;
    if ({pred_taken, pred_target, pred_meta} !== {1'b1, 32'h180, 12'h003}) begin
      n_bad++;
      $display("FAIL branch_taken: got %b %h %h want 1 00000180 003",
               pred_taken, pred_target, pred_meta);
    end
    feedback(32'h200, 0, 32'h0, 0, 12'h003, 1);
    feedback(32'h200, 0, 32'h0, 0, 12'h003, 1);
    lookup(32'h200);
    n_cmp++;
    if ({pred_taken, pred_target, pred_meta} !== {1'b0, 32'h204, 12'h001}) begin
      n_bad++;
      $display("FAIL branch_untrained: got %b %h %h want 0 00000204 001",
               pred_taken, pred_target, pred_meta);
    end
    n_cmp++;
    if (cnt_pred !== 32'd4 || cnt_hit !== 32'd2) begin
      n_bad++;
      $display("FAIL mispredict_cnt: got %0d %0d want 4 2", cnt_pred, cnt_hit);
    end
  endtask

  task automatic test_call_ret();
    feedback(32'h300, 1, 32'h400, 2, 12'h000, 0);
    feedback(32'h410, 1, 32'h0, 3, 12'h000, 0);
    lookup(32'h300);
    n_cmp++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h400) begin
      n_bad++;
      $display("FAIL call_pred: got %b %h want 1 00000400", pred_taken, pred_target);
    end
    lookup(32'h410);
    n_cmp++;
    if ({pred_taken, pred_target, pred_meta} !== {1'b1, 32'h304, 12'h401}) begin
      n_bad++;
      $display("FAIL ret_pred: got %b %h %h want 1 00000304 401",
               pred_taken, pred_target, pred_meta);
    end
  endtask

  task automatic test_ras_wrap();
    logic [31:0] want [5];
    want[0] = 32'h584; want[1] = 32'h564; want[2] = 32'h544;
    want[3] = 32'h524; want[4] = 32'h584;
    for (int i = 0; i < 5; i++)
      feedback(32'h500 + 32'(i * 32), 1, 32'h1000, 2, 12'h000, 0);
    for (int i = 0; i < 5; i++) lookup(32'h500 + 32'(i * 32));
    for (int i = 0; i < 5; i++) begin
      lookup(32'h410);
      n_cmp++;
      if (pred_target !== want[i]) begin
        n_bad++;
        $display("FAIL ras_wrap_%0d: got %h want %h", i, pred_target, want[i]);
      end
    end
  endtask

  task automatic test_mispredict_restore();
    feedback(32'h604, 1, 32'h700, 0, 12'h000, 0);
    feedback(32'h604, 1, 32'h700, 0, 12'h000, 0);
    lookup(32'h604);
    n_cmp++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h700) begin
      n_bad++;
      $display("FAIL spec_taken: got %b %h want 1 00000700", pred_taken, pred_target);
    end
    feedback(32'h604, 0, 32'h0, 0, {2'b00, 8'h5A, 2'b11}, 1);
    lookup(32'h100);
    n_cmp++;
    if (pred_meta[9:2] !== 8'hB4 || pred_target !== 32'h104) begin
      n_bad++;
      $display("FAIL ghr_restore: got ghr %h tgt %h want b4 00000104",
               pred_meta[9:2], pred_target);
    end
  endtask

  task automatic test_async_reset();
    int n;
    n_cmp++;
    if (cnt_pred !== e_cp) begin
      n_bad++; $display("FAIL pre_reset_cnt: got %0d want %0d", cnt_pred, e_cp);
    end
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    n_cmp++;
    if (busy !== 1'b1 ||
        {pred_taken, pred_target, pred_meta, cnt_pred, cnt_hit} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got busy %b outs %b %h %h %h %h want 1 and 0",
               busy, pred_taken, pred_target, pred_meta, cnt_pred, cnt_hit);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_reset();
    n = 0;
    while (busy && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    n_cmp++;
    if (n !== 256) begin
      n_bad++; $display("FAIL reinit_cycles: got %0d want 256", n);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc, fpc, ftgt;
    logic [1:0] fk;
    bit lk, fw, ft, fmis;
    for (int i = 0; i < 600; i++) begin
      lk   = ($urandom_range(0, 3) != 0);
      fw   = ($urandom_range(0, 1) != 0);
      pc   = (32'($urandom_range(0, 1)) << 10) | (32'($urandom_range(0, 7)) << 2);
      fpc  = (32'($urandom_range(0, 1)) << 10) | (32'($urandom_range(0, 7)) << 2);
      fk   = 2'($urandom_range(0, 3));
      ft   = (fk != 0) ? 1'b1 : 1'($urandom_range(0, 1));
      ftgt = $urandom & 32'hFFFF_FFFC;
      fmis = ($urandom_range(0, 3) == 0);
      step(lk, pc, fw, fpc, ft, ftgt, fk, 12'($urandom), fmis);
      n_cmp++;
      if (pred_taken !== e_taken || pred_target !== e_target) begin
        n_bad++;
        $display("FAIL rand_pred[%0d]: got %b %h want %b %h",
                 i, pred_taken, pred_target, e_taken, e_target);
      end
      n_cmp++;
      if (pred_meta !== e_meta) begin
        n_bad++;
        $display("FAIL rand_meta[%0d]: got %h want %h", i, pred_meta, e_meta);
      end
      n_cmp++;
      if (cnt_pred !== e_cp || cnt_hit !== e_ch) begin
        n_bad++;
        $display("FAIL rand_cnt[%0d]: got %0d %0d want %0d %0d",
                 i, cnt_pred, cnt_hit, e_cp, e_ch);
      end
    end
  endtask

  initial begin
    pred_oe = 0; pred_pc = 0; fb_we = 0; fb_pc = 0; fb_taken = 0;
    fb_target = 0; fb_kind = 0; fb_meta = 0; fb_mispredict = 0;
    model_reset();
    test_reset();
    test_first_lookup();
    test_branch_train();
    test_call_ret();
    test_ras_wrap();
    test_mispredict_restore();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
